seq_gen_moore: RTL
==================

# seq_gen_moore

Serial pattern generator that drives the serial sequence input of the team's Moore sequence detector. It loads a parallel pattern on a start request and shifts it out MSB-first, one bit per clock. The pattern repeats a programmed number of times with a programmable idle gap between repetitions. It is the stimulus/transmit side of the detector link, usable both in benches and in-system self-test.

## Interface
- PAT_W, 4: pattern width in bits, ≥ 2
- CNT_W, 4: width of repeat count
- GAP_W, 4: width of gap count
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- abort  in  1  synchronous cancel; wins over every other input except reset
- pattern  in  PAT_W  pattern to send, sampled on accepted start
- repeat  in  CNT_W  number of transmissions, sampled on accepted start
- gap  in  GAP_W  zero-bit cycles between repetitions, sampled on accepted start
- sequence_out  out  1  serial bit; connects to the detector's sequence_in
- sequence_valid  out  1  high while sequence_out carries a pattern (or parity) bit
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion

## Operation
- Moore FSM, states IDLE, SEND, PAR (only with macro), GAP, DONE; all outputs are functions of registered state/datapath only.
- Reset (reset==0 at an edge): state=IDLE; sequence_out=0, sequence_valid=0, busy=0, done=0; shift register, bit counter, repeat counter, and gap counter cleared.
- IDLE: on start=1, latch pattern into shift register, load repeat and gap, bit counter=PAT_W-1.
  - repeat≠0 → SEND.
  - repeat==0 → DONE directly; no bits are sent.
- SEND: sequence_out=shreg[PAT_W-1], sequence_valid=1; each edge shifts left by one and decrements the bit counter.
  - Last bit → PAR (if enabled), otherwise end-of-repetition.
- End-of-repetition: repeat counter decrements.
  - Remaining==0 → DONE.
  - Otherwise reload the shift register from the latched pattern copy, then → GAP if gap≠0, else → SEND (back-to-back, no bubble).
- GAP: sequence_out=0, sequence_valid=0 for exactly `gap` cycles, then → SEND.
- DONE: done=1, busy=1 for one cycle, then → IDLE.
- start while busy: ignored. Changes to pattern/repeat/gap while busy: no effect.
- abort=1 in any non-IDLE state: → IDLE at that edge, no done pulse, outputs return to reset values next cycle. abort in IDLE: no effect, even if start=1 in the same cycle.
- Counters never wrap: the bit counter reloads per repetition; the repeat counter stops at 0.

## Timing
- Start accepted at edge N → first bit (pattern MSB) on sequence_out during cycle N..N+1 (1-cycle latency).
- Transmission length: repeat·B + (repeat−1)·gap cycles, where B=PAT_W (PAT_W+1 with parity).
- done asserts the cycle after the final bit; busy falls the cycle after done.
- A new start is accepted in the cycle after done, i.e. in IDLE; this gives a minimum 2-cycle gap between back-to-back jobs.

## Configuration
- SEQ_GEN_PARITY_EN defined: after each repetition's PAT_W bits, state PAR emits one even-parity bit (XOR of pattern) with sequence_valid=1; B=PAT_W+1.
- Not defined: the PAR state, its logic, and the parity register are absent; B=PAT_W.

## Structure
- Package seq_gen_pkg: the state enum typedef (IDLE, SEND, PAR, GAP, DONE) and a localparam for the state encoding width.
- One sub-module, seq_piso: parallel-load, left-shifting register with load/shift enables and MSB output. The FSM and counters stay in seq_gen_moore.

## Test plan
- pattern=4'b1011, repeat=1, gap=0 → sequence_out 1,0,1,1 on the 4 cycles after the start edge; sequence_valid high for exactly 4 cycles; done one cycle later; the connected detector fires once.
- pattern=4'b1011, repeat=3, gap=2 → 1011,00,1011,00,1011; total 16 cycles; exactly one done.
- repeat=0 → sequence_valid never rises; done is pulsed the cycle after start.
- abort during the 2nd bit of repeat=2 → IDLE at that edge, no done; a start on the next cycle is accepted normally.
- reset=0 mid-GAP → all outputs 0 next cycle; start pulsed during reset is ignored. Second start while busy is ignored.
- SEQ_GEN_PARITY_EN defined, pattern=4'b1011 → 1,0,1,1,1 (parity=1); pattern=4'b1001 → parity bit 0.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types for the serial pattern generator: FSM state encoding.
package seq_gen_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    PAR  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/seq_gen_moore_if.sv
// Request/status bundle between a job requester (master) and seq_gen_moore (slave).
// 'repeat' is a reserved word, so the repetition count is carried on repeat_n.
interface seq_gen_moore_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             sequence_out;
  logic             sequence_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, repeat_n, gap,
    input  sequence_out, sequence_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, repeat_n, gap,
    output sequence_out, sequence_valid, busy, done
  );
endinterface

// File: rtl/seq_gen_moore_piso.sv
// Parallel-in serial-out register: load has priority over shift, shifts left, exposes MSB.
module seq_piso #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] q;

  always_ff @(posedge clock) begin
    if (!reset)     q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= {q[W-2:0], 1'b0};
  end

  assign msb = q[W-1];

endmodule

// File: rtl/seq_gen_moore.sv
// Moore serial pattern generator feeding the sequence detector: MSB-first, N repeats, idle gaps.
// Build option: define SEQ_GEN_PARITY_EN to append an even-parity bit after each repetition.
module seq_gen_moore
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic           clock,
  input  logic           reset,
  seq_gen_moore_if.slave bus
);

  localparam int              BC_W     = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(PAT_W - 1);

  state_t           st;
  logic [BC_W-1:0]  bit_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [PAT_W-1:0] pat_q;
`ifdef SEQ_GEN_PARITY_EN
  logic             par_q;
`endif

  logic             msb;
  logic             rep_end;
  logic             last_rep;
  logic             piso_load;
  logic             piso_shift;
  logic [PAT_W-1:0] piso_din;

  // End of a repetition: last data bit, or the parity bit when enabled.
  always_comb begin
`ifdef SEQ_GEN_PARITY_EN
    rep_end    = !bus.abort && (st == PAR);
`else
    rep_end    = !bus.abort && (st == SEND) && (bit_cnt == '0);
`endif
    last_rep   = (rep_cnt == CNT_W'(1));
    piso_load  = ((st == IDLE) && bus.start) || (rep_end && !last_rep);
    piso_din   = (st == IDLE) ? bus.pattern : pat_q;
    piso_shift = (st == SEND) && !bus.abort;
  end

  seq_piso #(.W(PAT_W)) u_piso (
    .clock (clock),
    .reset (reset),
    .load  (piso_load),
    .shift (piso_shift),
    .din   (piso_din),
    .msb   (msb)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      st      <= IDLE;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      pat_q   <= '0;
`ifdef SEQ_GEN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (bus.abort && (st != IDLE)) begin
      st <= IDLE;
    end else begin
      case (st)
        IDLE: if (bus.start) begin
          pat_q   <= bus.pattern;
          rep_cnt <= bus.repeat_n;
          gap_q   <= bus.gap;
          bit_cnt <= BIT_LAST;
`ifdef SEQ_GEN_PARITY_EN
          par_q   <= ^bus.pattern;
`endif
          st      <= (bus.repeat_n == '0) ? DONE : SEND;
        end
        SEND: begin
          if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
`ifdef SEQ_GEN_PARITY_EN
          else               st      <= PAR;
`endif
        end
`ifdef SEQ_GEN_PARITY_EN
        PAR: ;
`endif
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == GAP_W'(1)) st <= SEND;
        end
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase

      // Repetition wrap-up overrides the per-state updates above.
      if (rep_end) begin
        rep_cnt <= rep_cnt - 1'b1;
        bit_cnt <= BIT_LAST;
        if (last_rep) st <= DONE;
        else if (gap_q != '0) begin
          st      <= GAP;
          gap_cnt <= gap_q;
        end else st <= SEND;
      end
    end
  end

  always_comb begin
    bus.sequence_out = 1'b0;
    if (st == SEND) bus.sequence_out = msb;
`ifdef SEQ_GEN_PARITY_EN
    if (st == PAR)  bus.sequence_out = par_q;
    bus.sequence_valid = (st == SEND) || (st == PAR);
`else
    bus.sequence_valid = (st == SEND);
`endif
  end

  assign bus.busy = (st != IDLE);
  assign bus.done = (st == DONE);

endmodule
